// File: rtl/axi_read_addr_decoder.sv
// axi_read_addr_decoder: takes one arbitrated AR request at a time, decodes
// ARADDR to S0, S1 or an internal DECERR default slave, issues the request
// on the shared slave AR bus and routes the R burst back to the owner.
// Ports: ACLK/ARESETn; *_ARB + M0/M1_flag arbiter side; ARID_S..ARBURST_S,
// ARVALID_S*/ARREADY_S*, R*_S*/RREADY_S* slave side; R*_M, RVALID_M*,
// RREADY_M* master side; RVALID_ARB any routed beat valid.
// Macro AXI_RDEC_LASTCHK_EN: RLAST_M from the beat count, RLAST_Sx
// mismatches reported as SLVERR, extra sticky output lastchk_err.
module axi_read_addr_decoder #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int DATA_BITS = 32,
    parameter logic [ADDR_BITS-1:0] S0_BASE = ADDR_BITS'(32'h0000_0000),
    parameter logic [ADDR_BITS-1:0] S1_BASE = ADDR_BITS'(32'h0001_0000)
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [ID_BITS-1:0]   ARID_ARB,
    input  logic [ADDR_BITS-1:0] ARADDR_ARB,
    input  logic [LEN_BITS-1:0]  ARLEN_ARB,
    input  logic [2:0]           ARSIZE_ARB,
    input  logic [1:0]           ARBURST_ARB,
    input  logic                 ARVALID_ARB,
    input  logic                 M0_flag,
    input  logic                 M1_flag,
    output logic                 ARREADY_ARB,
    output logic [ID_BITS+3:0]   ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [2:0]           ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S0,
    output logic                 ARVALID_S1,
    input  logic                 ARREADY_S0,
    input  logic                 ARREADY_S1,
    input  logic [ID_BITS+3:0]   RID_S0,
    input  logic [ID_BITS+3:0]   RID_S1,
    input  logic [DATA_BITS-1:0] RDATA_S0,
    input  logic [DATA_BITS-1:0] RDATA_S1,
    input  logic [1:0]           RRESP_S0,
    input  logic [1:0]           RRESP_S1,
    input  logic                 RLAST_S0,
    input  logic                 RLAST_S1,
    input  logic                 RVALID_S0,
    input  logic                 RVALID_S1,
    output logic                 RREADY_S0,
    output logic                 RREADY_S1,
    output logic [ID_BITS-1:0]   RID_M,
    output logic [DATA_BITS-1:0] RDATA_M,
    output logic [1:0]           RRESP_M,
    output logic                 RLAST_M,
    output logic                 RVALID_ARB,
    output logic                 RVALID_M0,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M0,
    input  logic                 RREADY_M1
`ifdef AXI_RDEC_LASTCHK_EN
    ,
    output logic                 lastchk_err
`endif
);

    localparam int CW = LEN_BITS + 1;
    localparam logic [ADDR_BITS-1:0] WIN = ADDR_BITS'(32'h0000_FFFF);
    localparam logic [ADDR_BITS-1:0] S0_END = S0_BASE + WIN;
    localparam logic [ADDR_BITS-1:0] S1_END = S1_BASE + WIN;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DEFR
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 tgt_q, tgt_d;
    logic [ID_BITS+3:0]   aid_q, aid_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 in_s0, in_s1, new_owner;
    logic                 s_rvalid, s_rlast, s_arready, m_rready;
    logic [DATA_BITS-1:0] s_rdata;
    logic [1:0]           s_rresp;
    logic [ID_BITS-1:0]   s_rid;
    logic                 cnt_last, rvalid, beat, data_end;
    logic [CW-1:0]        cnt_inc;
    logic                 unused_rid_hi;

    // Only the master-side ID bits travel back; the prefix is ours.
    assign unused_rid_hi = ^{RID_S0[ID_BITS+3:ID_BITS],
                             RID_S1[ID_BITS+3:ID_BITS]};

    assign in_s0 = (ARADDR_ARB >= S0_BASE) && (ARADDR_ARB <= S0_END);
    assign in_s1 = (ARADDR_ARB >= S1_BASE) && (ARADDR_ARB <= S1_END);
    // M0 wins if both flags are set; neither set also defaults to M0.
    assign new_owner = M1_flag && !M0_flag;

    assign s_rvalid  = tgt_q ? RVALID_S1  : RVALID_S0;
    assign s_rlast   = tgt_q ? RLAST_S1   : RLAST_S0;
    assign s_arready = tgt_q ? ARREADY_S1 : ARREADY_S0;
    assign s_rdata   = tgt_q ? RDATA_S1   : RDATA_S0;
    assign s_rresp   = tgt_q ? RRESP_S1   : RRESP_S0;
    assign s_rid     = tgt_q ? RID_S1[ID_BITS-1:0] : RID_S0[ID_BITS-1:0];
    assign m_rready  = owner_q ? RREADY_M1 : RREADY_M0;

    assign cnt_last = (cnt_q == {1'b0, len_q});
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Held low through reset so no READY is advertised before release.
    assign ARREADY_ARB = ARESETn && (state_q == IDLE);

    assign ARVALID_S0 = (state_q == ADDR) && !tgt_q;
    assign ARVALID_S1 = (state_q == ADDR) && tgt_q;
    assign ARID_S     = aid_q;
    assign ARADDR_S   = addr_q;
    assign ARLEN_S    = len_q;
    assign ARSIZE_S   = size_q;
    assign ARBURST_S  = burst_q;

`ifdef AXI_RDEC_LASTCHK_EN
    assign data_end    = cnt_last;
    assign lastchk_err = err_q;
`else
    assign data_end    = s_rlast;
`endif

    always_comb begin
        rvalid    = 1'b0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = 2'b00;
        RLAST_M   = 1'b0;
        RREADY_S0 = 1'b0;
        RREADY_S1 = 1'b0;
        unique case (state_q)
            DATA: begin
                rvalid    = s_rvalid;
                RID_M     = s_rid;
                RDATA_M   = s_rdata;
                RREADY_S0 = !tgt_q && m_rready;
                RREADY_S1 = tgt_q && m_rready;
`ifdef AXI_RDEC_LASTCHK_EN
                RLAST_M   = cnt_last;
                RRESP_M   = (s_rlast != cnt_last) ? 2'b10 : s_rresp;
`else
                RLAST_M   = s_rlast;
                RRESP_M   = s_rresp;
`endif
            end
            DEFR: begin
                rvalid  = 1'b1;
                RID_M   = aid_q[ID_BITS-1:0];
                RRESP_M = 2'b11;
                RLAST_M = cnt_last;
            end
            default: begin
            end
        endcase
    end

    assign RVALID_ARB = rvalid;
    assign RVALID_M0  = rvalid && !owner_q;
    assign RVALID_M1  = rvalid && owner_q;
    assign beat       = rvalid && m_rready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tgt_d   = tgt_q;
        aid_d   = aid_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (ARVALID_ARB) begin
                    owner_d = new_owner;
                    aid_d   = {new_owner ? 4'b0010 : 4'b0001, ARID_ARB};
                    addr_d  = ARADDR_ARB;
                    len_d   = ARLEN_ARB;
                    size_d  = ARSIZE_ARB;
                    burst_d = ARBURST_ARB;
                    cnt_d   = '0;
                    tgt_d   = !in_s0;
                    state_d = (in_s0 || in_s1) ? ADDR : DEFR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    cnt_d = cnt_inc;
`ifdef AXI_RDEC_LASTCHK_EN
                    if (s_rlast != cnt_last) begin
                        err_d = 1'b1;
                    end
`endif
                    if (data_end) begin
                        state_d = IDLE;
                    end
                end
            end
            DEFR: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            tgt_q   <= 1'b0;
            aid_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tgt_q   <= tgt_d;
            aid_q   <= aid_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_read_addr_decoder.sv
// tb_axi_read_addr_decoder: directed bench for the read-address decoder.
// Decode table plus hand sequences for stalls, DECERR, reset, turnaround.
module tb_axi_read_addr_decoder;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  ARID_ARB;
    logic [31:0] ARADDR_ARB;
    logic [3:0]  ARLEN_ARB;
    logic [2:0]  ARSIZE_ARB;
    logic [1:0]  ARBURST_ARB;
    logic        ARVALID_ARB, M0_flag, M1_flag, ARREADY_ARB;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S0, ARVALID_S1, ARREADY_S0, ARREADY_S1;
    logic [7:0]  RID_S0, RID_S1;
    logic [31:0] RDATA_S0, RDATA_S1;
    logic [1:0]  RRESP_S0, RRESP_S1;
    logic        RLAST_S0, RLAST_S1, RVALID_S0, RVALID_S1;
    logic        RREADY_S0, RREADY_S1;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M, RVALID_ARB, RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
`ifdef AXI_RDEC_LASTCHK_EN
    logic        lastchk_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_read_addr_decoder dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_ARB(ARID_ARB), .ARADDR_ARB(ARADDR_ARB),
        .ARLEN_ARB(ARLEN_ARB), .ARSIZE_ARB(ARSIZE_ARB),
        .ARBURST_ARB(ARBURST_ARB), .ARVALID_ARB(ARVALID_ARB),
        .M0_flag(M0_flag), .M1_flag(M1_flag),
        .ARREADY_ARB(ARREADY_ARB),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
        .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
        .RID_S0(RID_S0), .RID_S1(RID_S1),
        .RDATA_S0(RDATA_S0), .RDATA_S1(RDATA_S1),
        .RRESP_S0(RRESP_S0), .RRESP_S1(RRESP_S1),
        .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
        .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1),
        .RREADY_S0(RREADY_S0), .RREADY_S1(RREADY_S1),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
        .RLAST_M(RLAST_M), .RVALID_ARB(RVALID_ARB),
        .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1)
`ifdef AXI_RDEC_LASTCHK_EN
        ,
        .lastchk_err(lastchk_err)
`endif
    );

    // tgt: 0 = S0, 1 = S1, 2 = default slave
    typedef struct {
        logic [31:0] addr;
        logic        m0;
        logic        m1;
        logic [3:0]  id;
        logic [1:0]  tgt;
        logic        own;
        logic [7:0]  arid;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic clr_slave();
        ARREADY_S0 = 0; ARREADY_S1 = 0;
        RVALID_S0 = 0; RVALID_S1 = 0;
        RLAST_S0 = 0; RLAST_S1 = 0;
        RDATA_S0 = 0; RDATA_S1 = 0;
        RRESP_S0 = 0; RRESP_S1 = 0;
        RID_S0 = 0; RID_S1 = 0;
        RREADY_M0 = 0; RREADY_M1 = 0;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] l,
                       input logic [3:0] id, input logic m0,
                       input logic m1);
        ARVALID_ARB = 1; ARADDR_ARB = a; ARLEN_ARB = l;
        ARID_ARB = id; M0_flag = m0; M1_flag = m1;
        ARSIZE_ARB = 3'd2; ARBURST_ARB = 2'b01;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        req(v.addr, 4'd0, v.id, v.m0, v.m1);
        #1 chk($sformatf("v%0d_arready", n), ARREADY_ARB, 1);
        step();
        ARVALID_ARB = 0;
        #1;
        chk($sformatf("v%0d_arvalid_s0", n), ARVALID_S0, v.tgt == 0);
        chk($sformatf("v%0d_arvalid_s1", n), ARVALID_S1, v.tgt == 1);
        RREADY_M0 = 1; RREADY_M1 = 1;
        if (v.tgt != 2) begin
            chk($sformatf("v%0d_arid", n), ARID_S, v.arid);
            chk($sformatf("v%0d_araddr", n), ARADDR_S, v.addr);
            if (v.tgt == 0) ARREADY_S0 = 1;
            else ARREADY_S1 = 1;
            step();
            ARREADY_S0 = 0; ARREADY_S1 = 0;
            if (v.tgt == 0) begin
                RVALID_S0 = 1; RLAST_S0 = 1;
                RDATA_S0 = v.data; RID_S0 = v.arid;
            end else begin
                RVALID_S1 = 1; RLAST_S1 = 1;
                RDATA_S1 = v.data; RID_S1 = v.arid;
            end
            #1 chk($sformatf("v%0d_rdata", n), RDATA_M, v.data);
            chk($sformatf("v%0d_rresp", n), RRESP_M, 0);
        end else begin
            #1 chk($sformatf("v%0d_rresp", n), RRESP_M, 2'b11);
            chk($sformatf("v%0d_rdata", n), RDATA_M, 0);
        end
        chk($sformatf("v%0d_rid", n), RID_M, v.id);
        chk($sformatf("v%0d_rlast", n), RLAST_M, 1);
        chk($sformatf("v%0d_rvalid_m0", n), RVALID_M0, !v.own);
        chk($sformatf("v%0d_rvalid_m1", n), RVALID_M1, v.own);
        step();
        clr_slave();
        #1 chk($sformatf("v%0d_idle", n), ARREADY_ARB, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0040, 1, 0, 4'h5, 0, 0, 8'h15, 32'hA0A0_0001};
        vecs[1] = '{32'h0000_FFFF, 0, 1, 4'hA, 0, 1, 8'h2A, 32'hA0A0_0002};
        vecs[2] = '{32'h0001_0000, 1, 0, 4'h3, 1, 0, 8'h13, 32'hA0A0_0003};
        vecs[3] = '{32'h0001_FFFF, 0, 1, 4'hF, 1, 1, 8'h2F, 32'hA0A0_0004};
        vecs[4] = '{32'h0002_0000, 1, 0, 4'h1, 2, 0, 8'h00, 32'h0};
        vecs[5] = '{32'hFFFF_FFFC, 0, 0, 4'h7, 2, 0, 8'h00, 32'h0};

        ARESETn = 0;
        ARVALID_ARB = 0; ARADDR_ARB = 0; ARLEN_ARB = 0; ARID_ARB = 0;
        ARSIZE_ARB = 0; ARBURST_ARB = 0; M0_flag = 0; M1_flag = 0;
        clr_slave();
        #2;
        chk("rst_arready", ARREADY_ARB, 0);
        chk("rst_arvalid", {ARVALID_S0, ARVALID_S1}, 0);
        chk("rst_rvalid", {RVALID_ARB, RVALID_M0, RVALID_M1}, 0);
        chk("rst_rready", {RREADY_S0, RREADY_S1}, 0);
        chk("rst_rbus", {RID_M, RDATA_M, RRESP_M, RLAST_M}, 0);
        chk("rst_arid", ARID_S, 0);
        @(negedge ACLK);
        ARESETn = 1;
        #1 chk("post_rst_arready", ARREADY_ARB, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // S0 ready after 2 cycles; ARVALID_ARB held with a 2nd request
        req(32'h0000_0040, 4'd0, 4'h5, 1, 0);
        step();
        req(32'h0001_0200, 4'd0, 4'h6, 0, 1);
        RVALID_S0 = 1;
        #1 chk("a_arvalid_c1", ARVALID_S0, 1);
        chk("a_arid", ARID_S, 8'h15);
        chk("a_araddr", ARADDR_S, 32'h40);
        chk("a_arready_addr", ARREADY_ARB, 0);
        chk("a_addr_rready", RREADY_S0, 0);
        chk("a_addr_rvalid", RVALID_ARB, 0);
        step();
        #1 chk("a_arvalid_c2", ARVALID_S0, 1);
        step();
        ARREADY_S0 = 1;
        #1 chk("a_arvalid_c3", ARVALID_S0, 1);
        chk("a_arvalid_s1", ARVALID_S1, 0);
        step();
        ARREADY_S0 = 0;
        RVALID_S0 = 1; RLAST_S0 = 1; RDATA_S0 = 32'hDEAD_BEEF;
        RID_S0 = 8'h15; RREADY_M0 = 1;
        #1 chk("a_rvalid_m0", RVALID_M0, 1);
        chk("a_rvalid_m1", RVALID_M1, 0);
        chk("a_rdata", RDATA_M, 32'hDEAD_BEEF);
        chk("a_rready_s0", RREADY_S0, 1);
        chk("a_arready_data", ARREADY_ARB, 0);
        step();
        clr_slave();
        #1 chk("a_turn_arready", ARREADY_ARB, 1);
        chk("a_turn_arvalid", ARVALID_S1, 0);
        step();
        ARVALID_ARB = 0;
        #1 chk("a2_arvalid_s1", ARVALID_S1, 1);
        chk("a2_arvalid_s0", ARVALID_S0, 0);
        chk("a2_arid", ARID_S, 8'h26);
        ARREADY_S1 = 1;
        step();
        ARREADY_S1 = 0;
        RVALID_S1 = 1; RLAST_S1 = 1; RID_S1 = 8'h26;
        RDATA_S1 = 32'h0BAD_CAFE; RREADY_M1 = 1;
        #1 chk("a2_rvalid_m1", RVALID_M1, 1);
        chk("a2_rvalid_m0", RVALID_M0, 0);
        chk("a2_rid", RID_M, 4'h6);
        step();
        clr_slave();

        // M1 4-beat S1 burst with a 2-cycle master stall on beat 2
        req(32'h0001_0100, 4'd3, 4'hC, 0, 1);
        step();
        ARVALID_ARB = 0;
        ARREADY_S1 = 1;
        step();
        ARREADY_S1 = 0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_d;
            exp_d = 32'h1000_0000 + 32'(k);
            RVALID_S1 = 1; RDATA_S1 = exp_d;
            RLAST_S1 = (k == 3); RID_S1 = 8'h2C;
            if (k == 1) begin
                RREADY_M1 = 0;
                for (int s = 0; s < 2; s++) begin
                    #1 chk("b_stall_rready", RREADY_S1, 0);
                    chk("b_stall_rvalid", RVALID_M1, 1);
                    chk("b_stall_rdata", RDATA_M, exp_d);
                    step();
                end
            end
            RREADY_M1 = 1;
            #1 chk($sformatf("b%0d_rready", k), RREADY_S1, 1);
            chk($sformatf("b%0d_rdata", k), RDATA_M, exp_d);
            chk($sformatf("b%0d_rlast", k), RLAST_M, k == 3);
            chk($sformatf("b%0d_rvalid_m0", k), RVALID_M0, 0);
            step();
        end
        clr_slave();
        #1 chk("b_idle", ARREADY_ARB, 1);

        // default slave, 2 DECERR beats
        req(32'h0003_0000, 4'd1, 4'h4, 1, 0);
        step();
        ARVALID_ARB = 0;
        #1 chk("c_no_arvalid", {ARVALID_S0, ARVALID_S1}, 0);
        chk("c_rvalid", RVALID_M0, 1);
        chk("c_rresp", RRESP_M, 2'b11);
        chk("c_rdata", RDATA_M, 0);
        chk("c_rid", RID_M, 4'h4);
        chk("c_rlast0", RLAST_M, 0);
        step();
        #1 chk("c_hold_rvalid", RVALID_M0, 1);
        chk("c_hold_rlast", RLAST_M, 0);
        RREADY_M0 = 1;
        step();
        #1 chk("c_beat2_rlast", RLAST_M, 1);
        chk("c_beat2_rresp", RRESP_M, 2'b11);
        step();
        RREADY_M0 = 0;
        #1 chk("c_idle", ARREADY_ARB, 1);
        chk("c_idle_rvalid", RVALID_ARB, 0);

        // reset in the middle of a 4-beat S0 burst
        req(32'h0000_0100, 4'd3, 4'h1, 1, 0);
        step();
        ARVALID_ARB = 0;
        ARREADY_S0 = 1;
        step();
        ARREADY_S0 = 0;
        RVALID_S0 = 1; RDATA_S0 = 32'h55; RID_S0 = 8'h11; RREADY_M0 = 1;
        step();
        RDATA_S0 = 32'h66;
        #1 chk("d_mid_rvalid", RVALID_M0, 1);
        ARESETn = 0;
        #1 chk("d_rst_rvalid", {RVALID_ARB, RVALID_M0, RVALID_M1}, 0);
        chk("d_rst_rready", {RREADY_S0, RREADY_S1}, 0);
        chk("d_rst_arready", ARREADY_ARB, 0);
        chk("d_rst_rdata", RDATA_M, 0);
        clr_slave();
        ARESETn = 1;
        #1 chk("d_idle", ARREADY_ARB, 1);
        chk("d_idle_arvalid", ARVALID_S0, 0);

`ifdef AXI_RDEC_LASTCHK_EN
        chk("e_err_clear", lastchk_err, 0);
        req(32'h0000_0200, 4'd1, 4'h2, 1, 0);
        step();
        ARVALID_ARB = 0;
        ARREADY_S0 = 1;
        step();
        ARREADY_S0 = 0;
        RVALID_S0 = 1; RLAST_S0 = 1; RDATA_S0 = 32'h11;
        RID_S0 = 8'h12; RREADY_M0 = 1;
        #1 chk("e_b1_rresp", RRESP_M, 2'b10);
        chk("e_b1_rlast", RLAST_M, 0);
        step();
        RLAST_S0 = 0; RDATA_S0 = 32'h22;
        #1 chk("e_err_set", lastchk_err, 1);
        chk("e_b2_rlast", RLAST_M, 1);
        chk("e_b2_rvalid", RVALID_M0, 1);
        step();
        clr_slave();
        #1 chk("e_idle", ARREADY_ARB, 1);
        chk("e_err_sticky", lastchk_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_addr_decoder.md
Name: axi_read_addr_decoder

Overview:
- Sits directly downstream of the 2-master read-address arbiter.
- Accepts one arbitrated AR request at a time and decodes ARADDR to slave S0, slave S1, or an internal default slave.
- Issues the request to the selected slave, then routes that slave's R burst back to the owning master.
- Drives ARREADY_ARB and RVALID_ARB back to the arbiter.

Parameters:
- ID_BITS, 4, master-side ID width; slave-side ID is ID_BITS+4 ({4'b0001 M0 / 4'b0010 M1, ARID}).
- ADDR_BITS, 32, address width.
- LEN_BITS, 4, burst length width.
- DATA_BITS, 32, read data width.
- S0_BASE, 32'h0000_0000, S0 base address; S0 size 64 KiB.
- S1_BASE, 32'h0001_0000, S1 base address; S1 size 64 KiB.

Ports:
- ACLK in 1: clock.
- ARESETn in 1: reset.
- ARID_ARB / ARADDR_ARB / ARLEN_ARB in ID_BITS / ADDR_BITS / LEN_BITS: arbitrated AR request.
- ARSIZE_ARB / ARBURST_ARB in 3 / 2: arbitrated AR request.
- ARVALID_ARB in 1: arbitrated request valid.
- M0_flag / M1_flag in 1 each: owning master of the current request.
- ARREADY_ARB out 1: request accepted.
- ARID_S out ID_BITS+4: shared slave AR bus.
- ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S out: shared slave AR bus.
- ARVALID_S0 / ARVALID_S1 out 1 each: per-slave valid.
- ARREADY_S0 / ARREADY_S1 in 1 each: per-slave ready.
- RID_S0 / RID_S1 in ID_BITS+4: slave read ID.
- RDATA_S0 / RDATA_S1 in DATA_BITS: slave read data.
- RRESP_S0 / RRESP_S1 in 2: slave read response.
- RLAST_S0 / RLAST_S1 / RVALID_S0 / RVALID_S1 in 1: slave R handshake.
- RREADY_S0 / RREADY_S1 out 1: slave R ready.
- RID_M out ID_BITS: routed read ID.
- RDATA_M out DATA_BITS: routed read data.
- RRESP_M out 2: routed read response.
- RLAST_M out 1: routed last beat.
- RVALID_ARB out 1: any routed beat valid, fed to the arbiter.
- RVALID_M0 / RVALID_M1 out 1: RVALID qualified by owner.
- RREADY_M0 / RREADY_M1 in 1: master R ready.

Behaviour:
- Reset: ARESETn, asynchronous, active-low; clock ACLK.
  - State IDLE; all capture registers 0.
  - All VALID/READY outputs 0; RID_M/RDATA_M/RRESP_M/RLAST_M 0.
- States: IDLE, ADDR, DATA, DEFR.
- IDLE:
  - ARREADY_ARB = 1 combinationally.
  - On ARVALID_ARB, capture id/addr/len/size/burst and owner (M0_flag → 0, M1_flag → 1; neither set → M0).
  - Decode target: S0 if addr in [S0_BASE, S0_BASE+0xFFFF]; S1 likewise; else DEF.
  - Next state: ADDR if S0/S1; DEFR if DEF.
- ADDR:
  - ARVALID_Sx = 1 for the target only; shared AR bus driven from the capture registers, stable until handshake.
  - On ARREADY_Sx → DATA; beat counter cleared to 0.
  - ARREADY_ARB = 0 in every state except IDLE.
- DATA:
  - RID_M = RID_Sx[ID_BITS-1:0]; RDATA_M/RRESP_M/RLAST_M passed combinationally from the target slave.
  - RVALID_ARB = RVALID_Sx; RVALID_M{owner} = RVALID_Sx, other master 0.
  - RREADY_Sx = RREADY_M{owner}; non-target slave RREADY 0.
  - Each beat (valid & ready) increments the counter.
  - Beat with RLAST_Sx → IDLE on the next edge.
- DEFR (default slave):
  - Generates len+1 beats: RDATA_M = 0, RRESP_M = 2'b11 (DECERR), RID_M = captured id.
  - RLAST_M = 1 when counter == len.
  - RVALID held 1 until the master accepts each beat.
  - Last beat accepted → IDLE.
- Latency:
  - AR to slave ARVALID: 1 cycle after the IDLE capture.
  - R path: 0 cycles, combinational.
  - Minimum turnaround: 1 idle cycle after the last beat before the next capture.
- Counter: LEN_BITS+1 wide, saturating, never wraps.
- Simultaneous events: ARVALID_ARB is ignored outside IDLE. Slave RVALID in ADDR is ignored; RREADY_Sx stays 0.
- Reset mid-burst: immediate return to IDLE; slave-side protocol recovery is the slave's responsibility.
- RRESP from the slave is passed unmodified.

Optional Feature:
- Macro: AXI_RDEC_LASTCHK_EN.
- Defined:
  - In DATA, RLAST_M = (counter == captured len), regardless of RLAST_Sx.
  - Transaction ends on that beat.
  - A mismatch between RLAST_Sx and the counter forces RRESP_M = 2'b10 (SLVERR) on that beat.
  - Adds output port lastchk_err (1 bit), sticky high until reset.
- Undefined: RLAST_Sx passed through, no check, no extra port.

Test Plan:
- M0 request ARADDR=0x0000_0040, ARLEN=0; S0 ARREADY after 2 cycles, one beat RDATA=0xDEADBEEF, RLAST=1 → ARVALID_S0 for 3 cycles, ARID_S={4'b0001,ARID}; RVALID_M0=1, RVALID_M1=0, RDATA_M=0xDEADBEEF; back in IDLE next cycle.
- M1 request ARADDR=0x0001_0100, ARLEN=3; S1 streams 4 beats, RREADY_M1 low on beat 2 for 2 cycles → RREADY_S1 follows; 4 beats delivered in order; RLAST_M on beat 4 only.
- M0 request ARADDR=0x0003_0000, ARLEN=1 → no ARVALID_S0/S1; 2 beats RRESP=2'b11, RDATA=0; RLAST on the 2nd beat.
- ARVALID_ARB held high during DATA → ARREADY_ARB=0 until IDLE; second request accepted only after the last beat plus 1 cycle.
- ARESETn low in the middle of a 4-beat S0 burst → all VALID/READY outputs 0 immediately; state IDLE.
- With AXI_RDEC_LASTCHK_EN defined, ARLEN=1 and slave asserts RLAST on beat 1 → beat 1 RRESP_M=2'b10, lastchk_err=1; burst ends after beat 2.
